// File: rtl/alpha_pack_pkg.sv
// Shared state encoding, gate-count width and words-per-symbol sizing for alpha_pack_stream.
package alpha_pack_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_PACK  = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   localparam int unsigned GC_W = 48;

   // Symbols per output word; a gate-count tag steals the top GC_W bits.
   function automatic int unsigned syms_per_word(input int unsigned out_w,
                                                 input int unsigned sym_w,
                                                 input bit          tag_en);
      return tag_en ? (out_w - GC_W) / sym_w : out_w / sym_w;
   endfunction

endpackage

// File: rtl/alpha_pack_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags; DEPTH must be a power of two.
module alpha_pack_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_wr;
   logic             w_rd;

   // A write into a full FIFO is only legal when a read frees a slot in the same cycle.
   assign w_rd = i_rd && !o_empty;
   assign w_wr = i_wr && (!o_full || w_rd);

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/alpha_pack_stream.sv
// Delays RNG symbols through a primed circular RAM, packs them LSB-first and streams words out.
// Optional gate-count tagging of each word is enabled by defining ALPHA_PACK_GC_TAG_EN.
module alpha_pack_stream
   import alpha_pack_pkg::*;
#(
   parameter int unsigned SYM_W       = 2,
   parameter int unsigned OUT_W       = 128,
   parameter int unsigned DELAY_DEPTH = 1024,
   parameter int unsigned FIFO_DEPTH  = 16
) (
   input  logic                           clk200_i,
   input  logic                           alpha_pack_rstn,
   input  logic                           sym_valid_i,
   input  logic [SYM_W-1:0]               sym_i,
   input  logic [GC_W-1:0]                gc_i,
   input  logic                           sr_enable_i,
   input  logic [$clog2(DELAY_DEPTH)-1:0] sr_fiber_delay_i,
   input  logic                           sr_pair_delay_i,
   output logic [OUT_W-1:0]               m_axis_tdata,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic                           m_axis_tlast,
   output logic                           overflow_o,
   output logic [31:0]                    word_count_o,
   output logic [15:0]                    drop_count_o,
   output logic [1:0]                     state_o
);

`ifdef ALPHA_PACK_GC_TAG_EN
   localparam bit TAG_EN = 1'b1;
`else
   localparam bit TAG_EN = 1'b0;
`endif
   localparam int unsigned N  = syms_per_word(OUT_W, SYM_W, TAG_EN);
   localparam int unsigned DW = $clog2(DELAY_DEPTH);
   localparam int unsigned CW = $clog2(N);

   state_t           r_state, w_state_next;
   logic             r_en_d;
   logic [DW-1:0]    r_delay, r_wr_ptr, r_prime_cnt;
   logic [DW-1:0]    w_d_new, w_rd_addr;
   logic [SYM_W-1:0] r_ram [DELAY_DEPTH];
   logic             r_rd_valid;
   logic [SYM_W-1:0] r_rd_sym;
   logic [OUT_W-1:0] r_pack_word, w_pack_next;
   logic [CW-1:0]    r_pack_cnt;
   logic             r_push_valid, r_push_last;
   logic [OUT_W-1:0] r_push_data;
   logic             w_en_rise, w_strobe, w_prime_done, w_drained, w_flush_push;
   logic             w_fifo_full, w_fifo_empty, w_pop, w_push_ok, w_drop;
   logic [OUT_W:0]   w_fifo_dout;
   logic             r_overflow;
   logic [31:0]      r_word_count;
   logic [15:0]      r_drop_count;

   assign w_d_new      = sr_fiber_delay_i + DW'(sr_pair_delay_i);
   assign w_en_rise    = sr_enable_i && !r_en_d;
   assign w_strobe     = sym_valid_i && (r_state == ST_PRIME || r_state == ST_PACK);
   assign w_prime_done = w_strobe && (r_state == ST_PRIME) && (r_prime_cnt == r_delay - 1'b1);
   assign w_drained    = !r_rd_valid && !r_push_valid;
   assign w_rd_addr    = r_wr_ptr - r_delay;

   always_ff @(posedge clk200_i or negedge alpha_pack_rstn) begin
      if (!alpha_pack_rstn) begin
         r_state <= ST_IDLE;
         r_en_d  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_en_d  <= sr_enable_i;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_flush_push = 1'b0;
      unique case (r_state)
         ST_IDLE:  if (w_en_rise) w_state_next = (w_d_new != '0) ? ST_PRIME : ST_PACK;
         ST_PRIME: begin
            if (!sr_enable_i)      w_state_next = ST_FLUSH;
            else if (w_prime_done) w_state_next = ST_PACK;
         end
         ST_PACK:  if (!sr_enable_i) w_state_next = ST_FLUSH;
         // Let in-flight symbols land before deciding whether a partial word exists.
         ST_FLUSH: if (w_drained) begin
            w_flush_push = (r_pack_cnt != '0);
            w_state_next = ST_IDLE;
         end
         default:  w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk200_i) begin
      if (w_strobe) r_ram[r_wr_ptr] <= sym_i;
   end

`ifdef ALPHA_PACK_GC_TAG_EN
   logic [GC_W-1:0] r_rd_gc;
   always_ff @(posedge clk200_i or negedge alpha_pack_rstn) begin
      if (!alpha_pack_rstn)  r_rd_gc <= '0;
      else if (w_strobe)     r_rd_gc <= gc_i;
   end
`else
   logic w_unused_gc;
   assign w_unused_gc = ^gc_i;
`endif

   // PRIME emits zeros so stale RAM contents never reach the packer; D=0 bypasses the RAM.
   always_ff @(posedge clk200_i or negedge alpha_pack_rstn) begin
      if (!alpha_pack_rstn) begin
         r_delay     <= '0;
         r_wr_ptr    <= '0;
         r_prime_cnt <= '0;
         r_rd_valid  <= 1'b0;
         r_rd_sym    <= '0;
      end else begin
         r_rd_valid <= w_strobe;
         if (r_state == ST_IDLE) begin
            r_wr_ptr    <= '0;
            r_prime_cnt <= '0;
            if (w_en_rise) r_delay <= w_d_new;
         end else if (w_strobe) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_state == ST_PRIME) begin
               r_prime_cnt <= r_prime_cnt + 1'b1;
               r_rd_sym    <= '0;
            end else if (r_delay == '0) begin
               r_rd_sym <= sym_i;
            end else begin
               r_rd_sym <= r_ram[w_rd_addr];
            end
         end
      end
   end

   always_comb begin
      w_pack_next = r_pack_word;
      w_pack_next[r_pack_cnt*SYM_W +: SYM_W] = r_rd_sym;
`ifdef ALPHA_PACK_GC_TAG_EN
      if (r_pack_cnt == '0) w_pack_next[OUT_W-1 -: GC_W] = r_rd_gc;
`endif
   end

   always_ff @(posedge clk200_i or negedge alpha_pack_rstn) begin
      if (!alpha_pack_rstn) begin
         r_pack_word  <= '0;
         r_pack_cnt   <= '0;
         r_push_valid <= 1'b0;
         r_push_last  <= 1'b0;
         r_push_data  <= '0;
      end else begin
         r_push_valid <= 1'b0;
         r_push_last  <= 1'b0;
         if (r_rd_valid) begin
            if (r_pack_cnt == CW'(N-1)) begin
               r_push_valid <= 1'b1;
               r_push_data  <= w_pack_next;
               r_pack_word  <= '0;
               r_pack_cnt   <= '0;
            end else begin
               r_pack_word <= w_pack_next;
               r_pack_cnt  <= r_pack_cnt + 1'b1;
            end
         end else if (w_flush_push) begin
            r_push_valid <= 1'b1;
            r_push_last  <= 1'b1;
            r_push_data  <= r_pack_word;
            r_pack_word  <= '0;
            r_pack_cnt   <= '0;
         end
      end
   end

   assign w_pop     = m_axis_tready && !w_fifo_empty;
   assign w_push_ok = r_push_valid && (!w_fifo_full || w_pop);
   assign w_drop    = r_push_valid && w_fifo_full && !w_pop;

   alpha_pack_fifo #(
      .WIDTH (OUT_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk     (clk200_i),
      .i_rst_n   (alpha_pack_rstn),
      .i_wr      (w_push_ok),
      .i_wr_data ({r_push_last, r_push_data}),
      .i_rd      (w_pop),
      .o_rd_data (w_fifo_dout),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty)
   );

   always_ff @(posedge clk200_i or negedge alpha_pack_rstn) begin
      if (!alpha_pack_rstn) begin
         r_overflow   <= 1'b0;
         r_word_count <= '0;
         r_drop_count <= '0;
      end else begin
         if (w_push_ok) r_word_count <= r_word_count + 1'b1;
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != '1) r_drop_count <= r_drop_count + 1'b1;
         end
      end
   end

   assign m_axis_tvalid = !w_fifo_empty;
   assign m_axis_tdata  = w_fifo_empty ? '0 : w_fifo_dout[OUT_W-1:0];
   assign m_axis_tlast  = !w_fifo_empty && w_fifo_dout[OUT_W];
   assign overflow_o    = r_overflow;
   assign word_count_o  = r_word_count;
   assign drop_count_o  = r_drop_count;
   assign state_o       = r_state;

endmodule

// File: tb/tb_alpha_pack_stream.sv
// Scoreboard bench for alpha_pack_stream: expected words are queued as symbols are driven.
module tb_alpha_pack_stream;

   localparam int unsigned SYM_W       = 2;
   localparam int unsigned OUT_W       = 128;
   localparam int unsigned DELAY_DEPTH = 1024;
   localparam int unsigned FIFO_DEPTH  = 16;
   localparam int unsigned DW          = $clog2(DELAY_DEPTH);
`ifdef ALPHA_PACK_GC_TAG_EN
   localparam int unsigned N = (OUT_W - 48) / SYM_W;
`else
   localparam int unsigned N = OUT_W / SYM_W;
`endif

   typedef struct packed {
      logic             last;
      logic [OUT_W-1:0] data;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             sym_valid = 1'b0;
   logic [SYM_W-1:0] sym = '0;
   logic [47:0]      gc = '0;
   logic             sr_enable = 1'b0;
   logic [DW-1:0]    sr_fiber = '0;
   logic             sr_pair = 1'b0;
   logic [OUT_W-1:0] m_axis_tdata;
   logic             m_axis_tvalid;
   logic             m_axis_tready = 1'b0;
   logic             m_axis_tlast;
   logic             overflow;
   logic [31:0]      word_count;
   logic [15:0]      drop_count;
   logic [1:0]       state;

   always #5 clk = ~clk;

   alpha_pack_stream #(
      .SYM_W       (SYM_W),
      .OUT_W       (OUT_W),
      .DELAY_DEPTH (DELAY_DEPTH),
      .FIFO_DEPTH  (FIFO_DEPTH)
   ) dut (
      .clk200_i         (clk),
      .alpha_pack_rstn  (rst_n),
      .sym_valid_i      (sym_valid),
      .sym_i            (sym),
      .gc_i             (gc),
      .sr_enable_i      (sr_enable),
      .sr_fiber_delay_i (sr_fiber),
      .sr_pair_delay_i  (sr_pair),
      .m_axis_tdata     (m_axis_tdata),
      .m_axis_tvalid    (m_axis_tvalid),
      .m_axis_tready    (m_axis_tready),
      .m_axis_tlast     (m_axis_tlast),
      .overflow_o       (overflow),
      .word_count_o     (word_count),
      .drop_count_o     (drop_count),
      .state_o          (state)
   );

   beat_t exp_q[$];
   beat_t obs_q[$];
   int    checks = 0;
   int    failures = 0;

   always @(negedge clk) begin : monitor
      beat_t b;
      if (rst_n && m_axis_tvalid && m_axis_tready) begin
         b.last = m_axis_tlast;
         b.data = m_axis_tdata;
         obs_q.push_back(b);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [SYM_W-1:0] s);
      sym_valid = 1'b1;
      sym       = s;
      @(posedge clk);
      #1;
      sym_valid = 1'b0;
   endtask

   task automatic start(input logic [DW-1:0] fiber, input logic pair);
      sr_fiber  = fiber;
      sr_pair   = pair;
      sr_enable = 1'b1;
      cyc(1);
   endtask

   task automatic stop();
      sr_enable = 1'b0;
      cyc(8);
   endtask

   task automatic wait_obs(input int n);
      for (int i = 0; i < 400 && obs_q.size() < n; i++) cyc(1);
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      sr_enable     = 1'b0;
      sym_valid     = 1'b0;
      m_axis_tready = 1'b0;
      gc            = '0;
      cyc(2);
      exp_q.delete();
      obs_q.delete();
      rst_n = 1'b1;
      cyc(1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cyc(3);
      checks += 7;
      if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid: got %b expected 0", m_axis_tvalid); end
      if (m_axis_tdata !== '0)    begin failures++; $display("FAIL rst_tdata: got %h expected 0", m_axis_tdata); end
      if (m_axis_tlast !== 1'b0)  begin failures++; $display("FAIL rst_tlast: got %b expected 0", m_axis_tlast); end
      if (overflow !== 1'b0)      begin failures++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
      if (word_count !== 32'd0)   begin failures++; $display("FAIL rst_word_count: got %0d expected 0", word_count); end
      if (drop_count !== 16'd0)   begin failures++; $display("FAIL rst_drop_count: got %0d expected 0", drop_count); end
      if (state !== 2'd0)         begin failures++; $display("FAIL rst_state: got %0d expected 0", state); end
   endtask

   task automatic test_zero_delay();
      logic [OUT_W-1:0] w;
      logic [SYM_W-1:0] s;
      beat_t            e, o;
      do_reset();
      m_axis_tready = 1'b1;
      start('0, 1'b0);
      checks++;
      if (state !== 2'd2) begin failures++; $display("FAIL zd_state: got %0d expected 2", state); end
      w = '0;
      for (int i = 0; i < int'(N); i++) begin
         s = SYM_W'(i % 4);
         w[i*SYM_W +: SYM_W] = s;
         strobe(s);
         cyc(4);
      end
      e.last = 1'b0; e.data = w;
      exp_q.push_back(e);
      wait_obs(1);
      checks++;
      if (obs_q.size() < 1) begin
         failures++; $display("FAIL zd_beat: got 0 beats expected 1");
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("FAIL zd_word: got %b_%h expected %b_%h", o.last, o.data, e.last, e.data); end
      end
      checks++;
      if (word_count !== 32'd1) begin failures++; $display("FAIL zd_word_count: got %0d expected 1", word_count); end
      stop();
      checks += 2;
      if (state !== 2'd0) begin failures++; $display("FAIL zd_idle: got %0d expected 0", state); end
      if (obs_q.size() != 0) begin failures++; $display("FAIL zd_no_flush: got %0d beats expected 0", obs_q.size()); end
   endtask

   task automatic test_priming();
      logic [OUT_W-1:0] w;
      beat_t            e, o;
      do_reset();
      m_axis_tready = 1'b1;
      start(DW'(4), 1'b1);
      checks++;
      if (state !== 2'd1) begin failures++; $display("FAIL pr_state: got %0d expected 1", state); end
      w = '0;
      for (int i = 0; i < int'(N); i++) w[i*SYM_W +: SYM_W] = (i < 5) ? 2'd0 : 2'd3;
      e.last = 1'b0; e.data = w;
      exp_q.push_back(e);
      for (int i = 0; i < int'(N) + 5; i++) strobe(2'd3);
      wait_obs(1);
      cyc(5);
      checks += 2;
      if (obs_q.size() != 1) begin failures++; $display("FAIL pr_beats: got %0d expected 1", obs_q.size()); end
      if (word_count !== 32'd1) begin failures++; $display("FAIL pr_word_count: got %0d expected 1", word_count); end
      if (obs_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("FAIL pr_word: got %b_%h expected %b_%h", o.last, o.data, e.last, e.data); end
      end
      e.last = 1'b1; e.data = '0;
      e.data[9:0] = 10'h3FF;
      exp_q.push_back(e);
      stop();
      wait_obs(1);
      checks++;
      if (obs_q.size() < 1) begin
         failures++; $display("FAIL pr_flush_beat: got 0 beats expected 1");
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("FAIL pr_flush_word: got %b_%h expected %b_%h", o.last, o.data, e.last, e.data); end
      end
   endtask

   // keep_last: raise tready exactly while the final word's push collides with a full FIFO.
   task automatic run_fill(input string tag, input bit keep_last);
      logic [OUT_W-1:0] w;
      logic [SYM_W-1:0] s;
      beat_t            e, o;
      int               nexp;
      do_reset();
      start('0, 1'b0);
      w = '0;
      for (int i = 0; i < 17 * int'(N); i++) begin
         s = SYM_W'($urandom_range(3));
         w[(i % int'(N))*SYM_W +: SYM_W] = s;
         if (i % int'(N) == int'(N) - 1) begin
            e.last = 1'b0; e.data = w;
            if (keep_last || (i / int'(N)) < 16) exp_q.push_back(e);
            w = '0;
         end
         strobe(s);
      end
      nexp = exp_q.size();
      if (keep_last) begin
         @(posedge clk); #1;
         m_axis_tready = 1'b1;
         cyc(3);
         checks += 3;
         if (overflow !== 1'b0)    begin failures++; $display("FAIL %s_overflow: got %b expected 0", tag, overflow); end
         if (drop_count !== 16'd0) begin failures++; $display("FAIL %s_drop: got %0d expected 0", tag, drop_count); end
         if (word_count !== 32'd17) begin failures++; $display("FAIL %s_word_count: got %0d expected 17", tag, word_count); end
      end else begin
         cyc(5);
         checks += 5;
         if (overflow !== 1'b1)     begin failures++; $display("FAIL %s_overflow: got %b expected 1", tag, overflow); end
         if (drop_count !== 16'd1)  begin failures++; $display("FAIL %s_drop: got %0d expected 1", tag, drop_count); end
         if (word_count !== 32'd16) begin failures++; $display("FAIL %s_word_count: got %0d expected 16", tag, word_count); end
         if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL %s_tvalid_held: got %b expected 1", tag, m_axis_tvalid); end
         if (m_axis_tdata !== exp_q[0].data) begin failures++; $display("FAIL %s_tdata_held: got %h expected %h", tag, m_axis_tdata, exp_q[0].data); end
         m_axis_tready = 1'b1;
      end
      wait_obs(nexp);
      cyc(3);
      checks++;
      if (obs_q.size() != nexp) begin failures++; $display("FAIL %s_beats: got %0d expected %0d", tag, obs_q.size(), nexp); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("FAIL %s_order: got %b_%h expected %b_%h", tag, o.last, o.data, e.last, e.data); end
      end
      stop();
   endtask

   task automatic test_backpressure();
      run_fill("bp", 1'b0);
   endtask

   task automatic test_full_push_pop();
      run_fill("fpp", 1'b1);
   endtask

   task automatic test_flush();
      beat_t e, o;
      do_reset();
      m_axis_tready = 1'b1;
      start('0, 1'b0);
      e.last = 1'b1; e.data = '0;
      for (int i = 0; i < 10; i++) begin
         e.data[i*SYM_W +: SYM_W] = 2'd1;
         strobe(2'd1);
      end
      exp_q.push_back(e);
      stop();
      wait_obs(1);
      checks++;
      if (obs_q.size() < 1) begin
         failures++; $display("FAIL fl_beat: got 0 beats expected 1");
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks += 2;
         if (o.data !== 128'h55555) begin failures++; $display("FAIL fl_word: got %h expected %h", o.data, 128'h55555); end
         if (o.last !== 1'b1) begin failures++; $display("FAIL fl_tlast: got %b expected 1", o.last); end
      end
      checks++;
      if (state !== 2'd0) begin failures++; $display("FAIL fl_idle: got %0d expected 0", state); end
   endtask

   task automatic test_reset_mid_pack();
      beat_t e, o;
      do_reset();
      start('0, 1'b0);
      for (int i = 0; i < int'(N); i++) strobe(2'd1);
      for (int i = 0; i < 30; i++) strobe(2'd3);
      cyc(3);
      checks++;
      if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL rm_pre_tvalid: got %b expected 1", m_axis_tvalid); end
      #2 rst_n = 1'b0;
      sr_enable = 1'b0;
      #1;
      checks += 5;
      if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rm_tvalid: got %b expected 0", m_axis_tvalid); end
      if (m_axis_tdata !== '0)    begin failures++; $display("FAIL rm_tdata: got %h expected 0", m_axis_tdata); end
      if (word_count !== 32'd0)   begin failures++; $display("FAIL rm_word_count: got %0d expected 0", word_count); end
      if (drop_count !== 16'd0)   begin failures++; $display("FAIL rm_drop: got %0d expected 0", drop_count); end
      if (state !== 2'd0)         begin failures++; $display("FAIL rm_state: got %0d expected 0", state); end
      @(posedge clk); #1;
      cyc(2);
      obs_q.delete();
      exp_q.delete();
      rst_n = 1'b1;
      cyc(1);
      m_axis_tready = 1'b1;
      start(DW'(3), 1'b0);
      e.last = 1'b0; e.data = '0;
      for (int i = 0; i < int'(N); i++) begin
         e.data[i*SYM_W +: SYM_W] = (i < 3) ? 2'd0 : 2'd2;
         strobe(2'd2);
      end
      exp_q.push_back(e);
      wait_obs(1);
      checks++;
      if (obs_q.size() < 1) begin
         failures++; $display("FAIL rm_beat: got 0 beats expected 1");
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("FAIL rm_word: got %b_%h expected %b_%h", o.last, o.data, e.last, e.data); end
      end
      stop();
   endtask

`ifdef ALPHA_PACK_GC_TAG_EN
   task automatic test_gc_tag();
      beat_t e, o;
      do_reset();
      m_axis_tready = 1'b1;
      start('0, 1'b0);
      e.last = 1'b0; e.data = '0;
      e.data[OUT_W-1 -: 48] = 48'h000000000433;
      gc = 48'h000000000433;
      for (int i = 0; i < int'(N) - 1; i++) begin
         e.data[i*SYM_W +: SYM_W] = 2'd1;
         strobe(2'd1);
         gc = 48'hFFFF_FFFF_FFFF;
      end
      cyc(5);
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL gc_early: got %0d beats expected 0", obs_q.size()); end
      e.data[(N-1)*SYM_W +: SYM_W] = 2'd1;
      strobe(2'd1);
      exp_q.push_back(e);
      wait_obs(1);
      checks++;
      if (obs_q.size() < 1) begin
         failures++; $display("FAIL gc_beat: got 0 beats expected 1");
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks += 2;
         if (o.data[OUT_W-1 -: 48] !== 48'h000000000433) begin failures++; $display("FAIL gc_tag: got %h expected 000000000433", o.data[OUT_W-1 -: 48]); end
         if (o !== e) begin failures++; $display("FAIL gc_word: got %b_%h expected %b_%h", o.last, o.data, e.last, e.data); end
      end
      stop();
   endtask
`endif

   initial begin
      test_reset();
      test_zero_delay();
      test_priming();
      test_backpressure();
      test_full_push_pop();
      test_flush();
      test_reset_mid_pack();
`ifdef ALPHA_PACK_GC_TAG_EN
      test_gc_tag();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
